// File: rtl/board_validator_seq.sv
// Sequential chess move validator: checks one move request against the board and
// walks the path of long sliding moves one intermediate square per cycle.
module board_validator_seq #(
  parameter int DIM   = 8,
  parameter int PW    = 4,
  parameter int EMPTY = 12,
  parameter int CW    = $clog2(DIM)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [CW-1:0]                      old_x,
  input  logic [CW-1:0]                      old_y,
  input  logic [CW-1:0]                      new_x,
  input  logic [CW-1:0]                      new_y,
  input  logic [DIM-1:0][DIM-1:0][PW-1:0]    board_in,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic                               rsp_legal,
  output logic [2:0]                         rsp_reason,
  output logic                               busy
);

  typedef enum logic [1:0] {IDLE, DECODE, SCAN, RESP} state_t;

  localparam logic [2:0] R_OK    = 3'd0;
  localparam logic [2:0] R_NULL  = 3'd1;
  localparam logic [2:0] R_EMPTY = 3'd2;
  localparam logic [2:0] R_OWN   = 3'd3;
  localparam logic [2:0] R_GEO   = 3'd4;
  localparam logic [2:0] R_BLK   = 3'd5;
  localparam logic [2:0] R_OOR   = 3'd6;

  state_t        state;
  logic [CW-1:0] ox, oy, nx, ny;
  logic [CW-1:0] px, py, sx, sy, cnt;

  function automatic logic in_rng(input logic [CW-1:0] c);
    return int'(c) < DIM;
  endfunction

  // Off-board coordinates read as empty so no index >= DIM is ever used.
  function automatic logic [PW-1:0] sq(input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [PW-1:0] p;
    p = PW'(EMPTY);
    if (in_rng(x) && in_rng(y)) p = board_in[y][x];
    return p;
  endfunction

  function automatic logic is_occ(input logic [PW-1:0] p);
    return int'(p) < 12;
  endfunction

  function automatic logic is_white(input logic [PW-1:0] p);
    return int'(p) < 6;
  endfunction

  function automatic logic [2:0] kind(input logic [PW-1:0] p);
    return 3'(is_white(p) ? p : p - PW'(6));
  endfunction

  logic signed [CW:0] dx, dy, ax, ay, dd, dy_f;
  logic [PW-1:0]      src_p, dst_p;
  logic [CW-1:0]      stx, sty;
  logic               src_w, dst_occ, geo_ok, slide, p_step, p_dbl, p_blk;
  logic [2:0]         dec_reason;
  logic               dec_scan;

  always_comb begin
    src_p   = sq(ox, oy);
    dst_p   = sq(nx, ny);
    src_w   = is_white(src_p);
    dst_occ = is_occ(dst_p);
    dx      = $signed({1'b0, nx}) - $signed({1'b0, ox});
    dy      = $signed({1'b0, ny}) - $signed({1'b0, oy});
    ax      = dx[CW] ? -dx : dx;
    ay      = dy[CW] ? -dy : dy;
    dd      = (ax > ay) ? ax : ay;
    // dy_f is dy measured in the mover's forward direction
    dy_f    = src_w ? dy : -dy;
    stx     = dx[CW] ? '1 : ((dx != 0) ? CW'(1) : '0);
    sty     = dy[CW] ? '1 : ((dy != 0) ? CW'(1) : '0);
    p_step  = (dx == 0) && (dy_f == 1);
    p_dbl   = (dx == 0) && (dy_f == 2) && (oy == (src_w ? CW'(1) : CW'(DIM - 2)));
    geo_ok  = 1'b0;
    slide   = 1'b0;
    p_blk   = 1'b0;
    case (kind(src_p))
      3'd0: begin geo_ok = (dx == 0) || (dy == 0); slide = 1'b1; end
      3'd1: geo_ok = ((ax == 1) && (ay == 2)) || ((ax == 2) && (ay == 1));
      3'd2: begin geo_ok = (ax == ay); slide = 1'b1; end
      3'd3: begin geo_ok = (dx == 0) || (dy == 0) || (ax == ay); slide = 1'b1; end
      3'd4: geo_ok = (dd == 1);
      default: begin
        geo_ok = p_step || p_dbl || ((ax == 1) && (dy_f == 1) && dst_occ);
        slide  = p_dbl;
        p_blk  = (p_step || p_dbl) && dst_occ;
      end
    endcase

    dec_reason = R_OK;
    dec_scan   = 1'b0;
    if (!(in_rng(ox) && in_rng(oy) && in_rng(nx) && in_rng(ny))) dec_reason = R_OOR;
    else if (dd == 0)                                             dec_reason = R_NULL;
    else if (!is_occ(src_p))                                      dec_reason = R_EMPTY;
    else if (!geo_ok)                                             dec_reason = R_GEO;
    else if (p_blk)                                               dec_reason = R_BLK;
    else if (dst_occ && (is_white(dst_p) == src_w))               dec_reason = R_OWN;
    else if (slide && (dd > 1))                                   dec_scan   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ox         <= '0;
      oy         <= '0;
      nx         <= '0;
      ny         <= '0;
      px         <= '0;
      py         <= '0;
      sx         <= '0;
      sy         <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_legal  <= 1'b0;
      rsp_reason <= R_OK;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          ox    <= old_x;
          oy    <= old_y;
          nx    <= new_x;
          ny    <= new_y;
          state <= DECODE;
        end
        DECODE: if (dec_scan) begin
          px    <= ox + stx;
          py    <= oy + sty;
          sx    <= stx;
          sy    <= sty;
          cnt   <= CW'(dd - 1);
          state <= SCAN;
        end else begin
          rsp_valid  <= 1'b1;
          rsp_legal  <= (dec_reason == R_OK);
          rsp_reason <= dec_reason;
          state      <= RESP;
        end
        // cnt holds the number of intermediate squares still to examine
        SCAN: if (is_occ(sq(px, py))) begin
          rsp_valid  <= 1'b1;
          rsp_legal  <= 1'b0;
          rsp_reason <= R_BLK;
          state      <= RESP;
        end else if (cnt == CW'(1)) begin
          rsp_valid  <= 1'b1;
          rsp_legal  <= 1'b1;
          rsp_reason <= R_OK;
          state      <= RESP;
        end else begin
          px  <= px + sx;
          py  <= py + sy;
          cnt <= cnt - CW'(1);
        end
        RESP: if (rsp_ready) begin
          rsp_valid  <= 1'b0;
          rsp_legal  <= 1'b0;
          rsp_reason <= R_OK;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_board_validator_seq.sv
// Bench for board_validator_seq: fixed move table, handshake corner cases, a DIM=6
// instance and random moves checked against a rule-level reference model.
module tb_board_validator_seq;
  logic clk = 1'b0;
  logic reset_n;
  logic req_valid, req_valid6, rsp_ready;
  logic req_ready, rsp_valid, rsp_legal, busy;
  logic req_ready6, rsp_valid6, rsp_legal6, busy6;
  logic [2:0] rsp_reason, rsp_reason6;
  logic [2:0] old_x, old_y, new_x, new_y;
  logic [7:0][7:0][3:0] board;
  logic [5:0][5:0][3:0] board6;
  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    int ox; int oy; int nx; int ny;
    int ax; int ay; int ac;
    int bx; int by; int bc;
    int rsn; int lat;
  } vec_t;
  vec_t vecs[21];

  always #5 clk = ~clk;

  board_validator_seq dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y), .board_in(board),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_legal(rsp_legal),
    .rsp_reason(rsp_reason), .busy(busy));

  board_validator_seq #(.DIM(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid6), .req_ready(req_ready6),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y), .board_in(board6),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready), .rsp_legal(rsp_legal6),
    .rsp_reason(rsp_reason6), .busy(busy6));

  task automatic check(input int act, input int exp, input string nm);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear8();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) board[y][x] = 4'd12;
  endtask

  // Reference verdict from the move rules; lat counts cycles from accept to rsp_valid.
  function automatic void model(input int ox, input int oy, input int nx, input int ny,
                                output int reason, output int lat);
    int dx, dy, adx, ady, d, sp, dp, t, fwd, sx, sy;
    bit sw, docc, ok, slide, pfwd;
    dx = nx - ox; dy = ny - oy;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    d = (adx > ady) ? adx : ady;
    reason = 0; lat = 2; ok = 0; slide = 0; pfwd = 0;
    if (d == 0) begin reason = 1; return; end
    sp = int'(board[oy][ox]);
    dp = int'(board[ny][nx]);
    if (sp > 11) begin reason = 2; return; end
    sw = (sp < 6); t = sp % 6; docc = (dp <= 11); fwd = sw ? 1 : -1;
    case (t)
      0: begin ok = (dx == 0) || (dy == 0); slide = 1; end
      1: ok = (adx * ady == 2);
      2: begin ok = (adx == ady); slide = 1; end
      3: begin ok = (dx == 0) || (dy == 0) || (adx == ady); slide = 1; end
      4: ok = (d == 1);
      default: begin
        if (dx == 0 && dy == fwd) begin ok = 1; pfwd = 1; end
        else if (dx == 0 && dy == 2 * fwd && oy == (sw ? 1 : 6)) begin ok = 1; pfwd = 1; slide = 1; end
        else if (adx == 1 && dy == fwd) ok = docc;
      end
    endcase
    if (!ok) begin reason = 4; return; end
    if (pfwd && docc) begin reason = 5; return; end
    if (docc && ((dp < 6) == sw)) begin reason = 3; return; end
    if (slide && d > 1) begin
      sx = int'(dx > 0) - int'(dx < 0);
      sy = int'(dy > 0) - int'(dy < 0);
      for (int k = 1; k < d; k++)
        if (int'(board[oy + k * sy][ox + k * sx]) <= 11) begin reason = 5; lat = 2 + k; return; end
      lat = 1 + d;
    end
  endfunction

  // Called just after a falling edge; returns on a falling edge with the DUT idle.
  task automatic do_move(input bit six, input int ox, input int oy, input int nx, input int ny,
                         input int er, input int el, input string nm);
    int c;
    bit busy_ok;
    check(int'(six ? req_ready6 : req_ready), 1, {nm, " req_ready"});
    old_x = 3'(ox); old_y = 3'(oy); new_x = 3'(nx); new_y = 3'(ny);
    if (six) req_valid6 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid6 = 1'b0;
    c = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk); c++;
      if (!(six ? busy6 : busy)) busy_ok = 1'b0;
    end while (!(six ? rsp_valid6 : rsp_valid) && c < 64);
    check(c, el, {nm, " latency"});
    check(int'(busy_ok), 1, {nm, " busy"});
    check(int'(six ? rsp_reason6 : rsp_reason), er, {nm, " reason"});
    check(int'(six ? rsp_legal6 : rsp_legal), int'(er == 0), {nm, " legal"});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check(int'(six ? rsp_valid6 : rsp_valid), 0, {nm, " rsp_valid drop"});
  endtask

  task automatic wait_rsp(input string nm);
    int c;
    c = 0;
    while (!rsp_valid && c < 64) begin @(negedge clk); c++; end
    check(int'(rsp_valid), 1, {nm, " rsp_valid"});
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_valid6 = 1'b0; rsp_ready = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0;
    clear8();
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++) board6[y][x] = 4'd12;

    //          ox oy nx ny  ax ay ac  bx by bc  rsn lat
    vecs[0]  = '{0, 0, 0, 7,  0, 0, 0,  0, 0, -1, 0, 8};
    vecs[1]  = '{0, 0, 0, 7,  0, 0, 0,  0, 3, 7,  5, 5};
    vecs[2]  = '{1, 0, 2, 2,  1, 0, 1,  0, 0, -1, 0, 2};
    vecs[3]  = '{3, 0, 3, 1,  3, 0, 3,  3, 1, 5,  3, 2};
    vecs[4]  = '{4, 1, 4, 3,  4, 1, 5,  4, 2, 7,  5, 3};
    vecs[5]  = '{4, 6, 3, 5,  4, 6, 11, 3, 5, 2,  0, 2};
    vecs[6]  = '{4, 6, 4, 5,  4, 6, 11, 0, 0, -1, 0, 2};
    vecs[7]  = '{2, 2, 2, 2,  2, 2, 4,  0, 0, -1, 1, 2};
    vecs[8]  = '{5, 5, 5, 6,  5, 5, 15, 0, 0, -1, 2, 2};
    vecs[9]  = '{2, 0, 2, 3,  2, 0, 2,  0, 0, -1, 4, 2};
    vecs[10] = '{1, 1, 2, 2,  1, 1, 5,  0, 0, -1, 4, 2};
    vecs[11] = '{1, 1, 1, 2,  1, 1, 5,  1, 2, 6,  5, 2};
    vecs[12] = '{0, 0, 7, 7,  0, 0, 8,  0, 0, -1, 0, 8};
    vecs[13] = '{7, 0, 2, 5,  7, 0, 3,  5, 2, 11, 5, 4};
    vecs[14] = '{4, 0, 6, 0,  4, 0, 4,  0, 0, -1, 4, 2};
    vecs[15] = '{2, 6, 2, 4,  2, 6, 11, 0, 0, -1, 0, 3};
    vecs[16] = '{2, 2, 2, 4,  2, 2, 5,  0, 0, -1, 4, 2};
    vecs[17] = '{4, 4, 5, 5,  4, 4, 10, 5, 5, 0,  0, 2};
    vecs[18] = '{0, 0, 3, 3,  0, 0, 2,  3, 3, 5,  3, 2};
    vecs[19] = '{0, 0, 3, 0,  0, 0, 0,  1, 0, 13, 0, 4};
    vecs[20] = '{7, 7, 7, 0,  7, 7, 6,  7, 0, 5,  0, 8};

    #12;
    check(int'(rsp_valid), 0, "reset rsp_valid");
    check(int'(rsp_legal), 0, "reset rsp_legal");
    check(int'(rsp_reason), 0, "reset rsp_reason");
    check(int'(busy), 0, "reset busy");
    check(int'(req_ready), 1, "reset req_ready");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      clear8();
      board[vecs[i].ay][vecs[i].ax] = 4'(vecs[i].ac);
      if (vecs[i].bc >= 0) board[vecs[i].by][vecs[i].bx] = 4'(vecs[i].bc);
      do_move(1'b0, vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny,
              vecs[i].rsn, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: response held, a request pulse during RESP is dropped.
    clear8();
    board[0][0] = 4'd0; board[3][0] = 4'd7;
    old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd7;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    wait_rsp("bp");
    for (int i = 0; i < 3; i++) begin
      check(int'(rsp_valid), 1, "bp hold rsp_valid");
      check(int'(rsp_reason), 5, "bp hold rsp_reason");
      check(int'(rsp_legal), 0, "bp hold rsp_legal");
      check(int'(req_ready), 0, "bp hold req_ready");
      if (i == 1) begin
        old_x = 3'd1; old_y = 3'd0; new_x = 3'd2; new_y = 3'd2;
        req_valid = 1'b1;
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    check(int'(busy), 0, "bp idle after handshake");
    check(int'(rsp_valid), 0, "bp rsp_valid dropped");
    @(negedge clk);
    check(int'(busy), 0, "bp pulse ignored");

    // Reset asserted at scan cycle 2 of a clear rook move.
    clear8();
    board[0][0] = 4'd0;
    old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd7;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check(int'(busy), 1, "mid-scan busy");
    reset_n = 1'b0;
    #1;
    check(int'(rsp_valid), 0, "scan reset rsp_valid");
    check(int'(rsp_legal), 0, "scan reset rsp_legal");
    check(int'(rsp_reason), 0, "scan reset rsp_reason");
    check(int'(busy), 0, "scan reset busy");
    check(int'(req_ready), 1, "scan reset req_ready");
    @(negedge clk);
    reset_n = 1'b1;
    do_move(1'b0, 0, 0, 0, 7, 0, 8, "after reset");

    // Reset asserted while a blocked verdict is pending.
    board[3][0] = 4'd7;
    old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd7;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    wait_rsp("resp reset");
    reset_n = 1'b0;
    #1;
    check(int'(rsp_valid), 0, "resp reset rsp_valid");
    check(int'(rsp_reason), 0, "resp reset rsp_reason");
    check(int'(req_ready), 1, "resp reset req_ready");
    @(negedge clk);
    reset_n = 1'b1;

    // DIM=6 instance: out-of-range coordinate and start row DIM-2.
    board6[5][5] = 4'd0;
    do_move(1'b1, 5, 5, 6, 5, 6, 2, "dim6 oor");
    board6[4][2] = 4'd11;
    do_move(1'b1, 2, 4, 2, 2, 0, 3, "dim6 bpawn dbl");
    board6[0][0] = 4'd0;
    do_move(1'b1, 0, 0, 0, 5, 0, 6, "dim6 rook");

    for (int n = 0; n < 200; n++) begin
      int ox, oy, nx, ny, er, el, s;
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++)
          board[y][x] = ($urandom_range(0, 99) < 35) ? 4'($urandom_range(0, 11))
                                                       : 4'($urandom_range(12, 15));
      ox = int'($urandom_range(0, 7));
      oy = int'($urandom_range(0, 7));
      if ($urandom_range(0, 9) != 0) board[oy][ox] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 0) begin
        nx = int'($urandom_range(0, 7));
        ny = int'($urandom_range(0, 7));
      end else begin
        s  = int'($urandom_range(1, 7));
        nx = ox + s * (int'($urandom_range(0, 2)) - 1);
        ny = oy + s * (int'($urandom_range(0, 2)) - 1);
        if (nx < 0) nx = 0;
        if (nx > 7) nx = 7;
        if (ny < 0) ny = 0;
        if (ny > 7) ny = 7;
      end
      model(ox, oy, nx, ny, er, el);
      do_move(1'b0, ox, oy, nx, ny, er, el, $sformatf("rnd%0d (%0d,%0d)->(%0d,%0d)", n, ox, oy, nx, ny));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/board_validator_seq.md
BOARD_VALIDATOR_SEQ -- requirements
Module: board_validator_seq

Interface
REQ-001 SHALL have parameter DIM, default 8, board edge length in squares (DIM >= 3).
REQ-002 SHALL have parameter PW, default 4, piece code width.
REQ-003 SHALL have parameter EMPTY, default 12, piece code for an empty square.
REQ-004 SHALL have parameter CW, default $clog2(DIM), coordinate width.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  1  move request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 old_x, old_y, new_x, new_y  in  CW each  source and destination coordinates.
REQ-010 board_in  in  [DIM][DIM] x PW  board, indexed board_in[y][x]; held stable from accept until response handshake.
REQ-011 rsp_valid  out  1  verdict available.
REQ-012 rsp_ready  in  1  consumer takes verdict.
REQ-013 rsp_legal  out  1  move is legal.
REQ-014 rsp_reason  out  3  verdict code: 0 OK, 1 NULL_MOVE, 2 EMPTY_SRC, 3 OWN_CAPTURE, 4 BAD_GEOMETRY, 5 BLOCKED, 6 OUT_OF_RANGE.
REQ-015 busy  out  1  request in progress, i.e. state is not IDLE.

Function
REQ-016 Piece codes:
- 0 rook, 1 knight, 2 bishop, 3 queen, 4 king, 5 pawn: white.
- 6..11: black, same order.
- Any code other than 0..11 counts as empty.
REQ-017 FSM states are IDLE, DECODE, SCAN, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE: on req_valid && req_ready (cycle T), register coordinates and go to DECODE.
REQ-019 DECODE (T+1) SHALL read the source piece, compute dx = new_x-old_x and dy = new_y-old_y (signed, CW+1 bits) and apply checks in priority order:
- OUT_OF_RANGE: any coordinate >= DIM.
- NULL_MOVE.
- EMPTY_SRC.
- BAD_GEOMETRY.
- OWN_CAPTURE: destination holds a same-colour piece.
REQ-020 First failing check SHALL go to RESP with that reason.
REQ-021 Geometry rules:
- Rook: dx=0 or dy=0.
- Bishop: |dx|=|dy|.
- Queen: rook or bishop rule.
- Knight: {|dx|,|dy|} = {1,2}.
- King: max(|dx|,|dy|)=1.
- Castling, en passant and promotion are not supported.
REQ-022 Pawn rules (white forward is +y, start row 1; black forward is -y, start row DIM-2):
- Single step: one square forward onto an empty destination.
- Double step: from the start row onto an empty destination, with the intermediate square scanned.
- Capture: diagonal forward by one, onto an opponent piece only.
- Forward step onto an occupied square gives BLOCKED.
- Diagonal onto an empty square gives BAD_GEOMETRY.
REQ-023 Sliding pieces (rook, bishop, queen, pawn double step) with distance d = max(|dx|,|dy|) > 1 SHALL go to SCAN; all other passing moves go to RESP with OK.
REQ-024 SCAN SHALL examine one intermediate square per cycle, stepping by (sign(dx), sign(dy)) with a CW-bit position counter, starting at source+step.
REQ-025 SCAN cycle k (k = 1..d-1) occurs at T+1+k.
REQ-026 A non-empty square in SCAN SHALL go to RESP with BLOCKED.
REQ-027 If the last intermediate square is clear, SCAN SHALL go to RESP with OK.
REQ-028 RESP: rsp_valid = 1, with rsp_legal = (rsp_reason == 0).
REQ-029 RESP SHALL hold all response outputs stable until rsp_ready, then return to IDLE the next cycle.
REQ-030 A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-031 Latency from accept cycle T to first rsp_valid:
- T+2 for non-scanned moves.
- T+2+k for a block detected at scan cycle k.
- T+1+d for a clear scan.
REQ-032 The block SHALL never read a board index >= DIM, including for non-power-of-two DIM.

Reset
REQ-033 reset_n low SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_legal=0, rsp_reason=0, busy=0, and clear all registered coordinates and counters, including when asserted mid-SCAN or mid-RESP.
REQ-034 The first accept after reset release SHALL be possible on the first rising edge with reset_n high.

Verification
REQ-035 Clear-column rook, DIM=8: white rook (0,0)->(0,7), column clear -> rsp_valid at T+8, legal=1, reason=0, busy high T+1..T+8.
REQ-036 Blocked rook: same move with black knight at (0,3) -> rsp_valid at T+5, legal=0, reason=5.
REQ-037 Knight and own capture:
- White knight (1,0)->(2,2) onto empty -> rsp_valid at T+2, legal=1.
- White queen (3,0)->(3,1) onto white pawn -> rsp_valid at T+2, reason=3.
REQ-038 Pawn cases:
- White pawn (4,1)->(4,3) with (4,2) occupied -> reason=5 at T+3.
- Black pawn (4,6)->(3,5) onto white bishop -> legal=1 at T+2.
- Black pawn (4,6)->(4,5) onto empty -> legal=1.
REQ-039 Backpressure and reset:
- rsp_ready held low 3 cycles in RESP -> rsp_valid and fields stable, req_ready=0, a req_valid pulse is ignored.
- reset_n pulsed low at scan cycle 2 -> all outputs at reset values in the same cycle, next request served normally.
REQ-040 Parameter check with DIM=6: inputs old=(5,5), new=(6,5) -> reason=6 at T+2, no out-of-bounds board access.
